// File: rtl/reg_file_if.sv
// Register-file access bus: ID-stage read ports, WB write port,
// load-pending scoreboard set port and the hazard/status outputs.
interface reg_file_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int REG_NUM    = 32
);
   logic                  read_en_1;
   logic [ADDR_WIDTH-1:0] read_addr_1;
   logic [DATA_WIDTH-1:0] read_data_1;
   logic                  read_en_2;
   logic [ADDR_WIDTH-1:0] read_addr_2;
   logic [DATA_WIDTH-1:0] read_data_2;
   logic                  write_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  pend_set_en;
   logic [ADDR_WIDTH-1:0] pend_set_addr;
   logic                  stall_req;
   logic [REG_NUM-1:0]    pending;

   // Pipeline side: drives addresses, enables and writeback data.
   modport master (
      output read_en_1, read_addr_1, read_en_2, read_addr_2,
      output write_en, write_addr, write_data,
      output pend_set_en, pend_set_addr,
      input  read_data_1, read_data_2, stall_req, pending
   );

   // Register-file side.
   modport slave (
      input  read_en_1, read_addr_1, read_en_2, read_addr_2,
      input  write_en, write_addr, write_data,
      input  pend_set_en, pend_set_addr,
      output read_data_1, read_data_2, stall_req, pending
   );
endinterface

// File: rtl/reg_file.sv
// MIPS architectural register file: 2 combinational read ports with
// same-cycle WB bypass, 1 write port, and a per-register pending-load
// scoreboard that requests an ID stall on a load-use hazard.
// Register 0 has no storage and no pending bit; it always reads zero.
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int REG_NUM    = 32
) (
   input logic       clk,
   input logic       rst_n,
   reg_file_if.slave bus
);

   // Storage and scoreboard for r1..r(REG_NUM-1) only.
   logic [REG_NUM-1:1][DATA_WIDTH-1:0] regs_q, regs_d;
   logic [REG_NUM-1:1]                 pend_q, pend_d;
   logic [REG_NUM-1:0]                 pend_full;

   // Per-register next state: write on WB hit; pending set wins over clear.
   for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_reg
      logic wr_hit;
      logic set_hit;
      assign wr_hit     = bus.write_en    && (bus.write_addr    == ADDR_WIDTH'(gi));
      assign set_hit    = bus.pend_set_en && (bus.pend_set_addr == ADDR_WIDTH'(gi));
      assign regs_d[gi] = wr_hit ? bus.write_data : regs_q[gi];
      assign pend_d[gi] = set_hit ? 1'b1 : (wr_hit ? 1'b0 : pend_q[gi]);
   end

   // State register: asynchronous reset clears all data and pending bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   assign pend_full   = {pend_q, 1'b0};
   assign bus.pending = pend_full;

   // Read port 1: disable, zero register, bypass, then stored value.
   always_comb begin
      bus.read_data_1 = '0;
      if (bus.read_en_1 && (bus.read_addr_1 != '0)) begin
         if (bus.write_en && (bus.write_addr == bus.read_addr_1))
            bus.read_data_1 = bus.write_data;
         else
            bus.read_data_1 = regs_q[bus.read_addr_1];
      end
   end

   // Read port 2: same priority as port 1.
   always_comb begin
      bus.read_data_2 = '0;
      if (bus.read_en_2 && (bus.read_addr_2 != '0)) begin
         if (bus.write_en && (bus.write_addr == bus.read_addr_2))
            bus.read_data_2 = bus.write_data;
         else
            bus.read_data_2 = regs_q[bus.read_addr_2];
      end
   end

   // Load-use hazard: a pending source stalls unless WB bypasses it this cycle.
   always_comb begin
      bus.stall_req = 1'b0;
      if (bus.read_en_1 && (bus.read_addr_1 != '0) && pend_full[bus.read_addr_1] &&
          !(bus.write_en && (bus.write_addr == bus.read_addr_1)))
         bus.stall_req = 1'b1;
      if (bus.read_en_2 && (bus.read_addr_2 != '0) && pend_full[bus.read_addr_2] &&
          !(bus.write_en && (bus.write_addr == bus.read_addr_2)))
         bus.stall_req = 1'b1;
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, table of per-cycle vectors, and an
// asynchronous mid-run reset sequence.
module tb_reg_file;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_NUM(32)) bus ();

   reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_NUM(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en1;
      logic [4:0]  a1;
      logic        en2;
      logic [4:0]  a2;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        pse;
      logic [4:0]  psa;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        es;
      logic [31:0] ep;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.read_en_1     = v.en1;
      bus.read_addr_1   = v.a1;
      bus.read_en_2     = v.en2;
      bus.read_addr_2   = v.a2;
      bus.write_en      = v.we;
      bus.write_addr    = v.wa;
      bus.write_data    = v.wd;
      bus.pend_set_en   = v.pse;
      bus.pend_set_addr = v.psa;
   endtask

   task automatic chk_outputs(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                              input logic es, input logic [31:0] ep);
      chk({tag, " rd1"},   bus.read_data_1, e1);
      chk({tag, " rd2"},   bus.read_data_2, e2);
      chk({tag, " stall"}, {31'd0, bus.stall_req}, {31'd0, es});
      chk({tag, " pend"},  bus.pending, ep);
   endtask

   initial begin
      // en1 a1 en2 a2  we wa wd            pse psa  e1            e2            es  pending
      vecs[0]  = '{1, 5, 1, 31, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0};
      vecs[1]  = '{1, 8, 1, 8,  1, 8, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h0};
      vecs[2]  = '{1, 8, 0, 8,  0, 0, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0,        0, 32'h0};
      vecs[3]  = '{1, 0, 1, 0,  1, 0, 32'h12345678, 1, 0, 32'h0,        32'h0,        0, 32'h0};
      vecs[4]  = '{1, 0, 1, 8,  0, 0, 32'h0,        1, 9, 32'h0,        32'hDEADBEEF, 0, 32'h0};
      vecs[5]  = '{1, 8, 1, 9,  0, 0, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0,        1, 32'h0000_0200};
      vecs[6]  = '{0, 9, 0, 9,  0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0000_0200};
      vecs[7]  = '{0, 0, 1, 9,  1, 9, 32'hA5A5A5A5, 0, 0, 32'h0,        32'hA5A5A5A5, 0, 32'h0000_0200};
      vecs[8]  = '{0, 0, 1, 9,  0, 0, 32'h0,        1, 4, 32'h0,        32'hA5A5A5A5, 0, 32'h0};
      vecs[9]  = '{1, 4, 0, 0,  1, 4, 32'h11,       1, 4, 32'h11,       32'h0,        0, 32'h0000_0010};
      vecs[10] = '{1, 4, 1, 4,  0, 0, 32'h0,        0, 0, 32'h11,       32'h11,       1, 32'h0000_0010};
      vecs[11] = '{1, 6, 1, 4,  1, 4, 32'h22,       1, 6, 32'h0,        32'h22,       0, 32'h0000_0010};
      vecs[12] = '{1, 6, 1, 4,  0, 0, 32'h0,        0, 0, 32'h0,        32'h22,       1, 32'h0000_0040};
      vecs[13] = '{1, 3, 0, 0,  1, 3, 32'h77,       0, 0, 32'h77,       32'h0,        0, 32'h0000_0040};

      // Reset held: reads of r5/r31 give zero, and a pend_set under reset is ignored.
      drive('{1, 5, 1, 31, 0, 0, 32'h0, 1, 5, 32'h0, 32'h0, 0, 32'h0});
      repeat (2) @(posedge clk);
      #1;
      chk_outputs("reset", 32'h0, 32'h0, 1'b0, 32'h0);
      $display("reset held: rd1=%h rd2=%h stall=%b pend=%h",
               bus.read_data_1, bus.read_data_2, bus.stall_req, bus.pending);
      bus.pend_set_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_outputs("post_reset", 32'h0, 32'h0, 1'b0, 32'h0);
      $display("reset released: rd1=%h rd2=%h stall=%b pend=%h",
               bus.read_data_1, bus.read_data_2, bus.stall_req, bus.pending);

      // Table: each vector occupies one cycle; outputs sampled at the falling edge.
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i]);
         @(negedge clk);
         chk_outputs($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].es, vecs[i].ep);
         $display("vec %0d: rd1=%h rd2=%h stall=%b pend=%h",
                  i, bus.read_data_1, bus.read_data_2, bus.stall_req, bus.pending);
         @(posedge clk);
         #1;
      end

      // Async reset mid-run: r3 = 0x77 stored, r6 pending.
      drive('{1, 3, 1, 6, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0});
      #1;
      chk_outputs("pre_areset", 32'h77, 32'h0, 1'b1, 32'h0000_0040);
      $display("before async reset: rd1=%h stall=%b pend=%h",
               bus.read_data_1, bus.stall_req, bus.pending);
      #1 rst_n = 1'b0;
      #1;
      chk_outputs("areset", 32'h0, 32'h0, 1'b0, 32'h0);
      $display("async reset asserted: rd1=%h stall=%b pend=%h",
               bus.read_data_1, bus.stall_req, bus.pending);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.read_addr_1 = 5'd8;
      bus.read_addr_2 = 5'd9;
      #1;
      chk_outputs("post_areset", 32'h0, 32'h0, 1'b0, 32'h0);
      $display("after async reset: r8=%h r9=%h stall=%b pend=%h",
               bus.read_data_1, bus.read_data_2, bus.stall_req, bus.pending);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
